commit_trace_fifo: RTL



---
 rtl/commit_trace_fifo_pkg.sv | 35 +++
 rtl/commit_trace_fifo_pack.sv | 24 ++
 rtl/commit_trace_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/commit_trace_fifo_pkg.sv
// Shared types for the commit trace capture path: clock bundle, writeback
// request shapes and the trace record pushed into the commit FIFO.
package commit_trace_fifo_pkg;

  typedef logic [4:0] RegAddr_t;

  typedef struct packed {
    logic base;
    logic rst;
  } Clock_t;

  typedef struct packed {
    logic     we;
    RegAddr_t waddr;
    logic [31:0] wdata;
  } RegWriteReq_t;

  typedef struct packed {
    logic        we;
    logic [63:0] wdata;
  } HiloWriteReq_t;

  typedef enum logic [0:0] {TRACE_REG, TRACE_HILO} TraceKind_t;

  typedef struct packed {
    TraceKind_t  kind;
    RegAddr_t    waddr;
    logic [63:0] wdata;
    logic [31:0] cycle;
  } CommitTrace_t;

  localparam int TRACE_SLOTS = 4;
  localparam int SLOT_CNT_W  = 3;

endpackage

// File: rtl/commit_trace_fifo_pack.sv
// Compacts up to four candidate commit records, keeping their slot order,
// into the low entries of a dense array and reports how many are valid.
module commit_trace_pack
  import commit_trace_fifo_pkg::*;
(
  input  CommitTrace_t            cand  [TRACE_SLOTS],
  input  logic [TRACE_SLOTS-1:0]  valid,
  output CommitTrace_t            dense [TRACE_SLOTS],
  output logic [SLOT_CNT_W-1:0]   count
);

  // Walk candidates in fixed order; each valid one lands at the next free slot.
  always_comb begin
    for (int i = 0; i < TRACE_SLOTS; i++) dense[i] = '0;
    count = '0;
    for (int i = 0; i < TRACE_SLOTS; i++) begin
      if (valid[i]) begin
        dense[count[1:0]] = cand[i];
        count = count + SLOT_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// Captures up to four architectural commits per cycle from writeback, stamps
// them with the capture cycle and queues them; drains one record per cycle.
// Handshake: a record transfers on a rising edge where trace_valid && trace_ready;
// trace/trace_valid hold steady while trace_valid && !trace_ready.
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  Clock_t                   clk,
  input  logic                     capture_en,
  input  RegWriteReq_t             reg_wr1,
  input  RegWriteReq_t             reg_wr2,
  input  HiloWriteReq_t            hilo_wr1,
  input  HiloWriteReq_t            hilo_wr2,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output CommitTrace_t             trace,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic clk_base;
  logic rst;
  assign clk_base = clk.base;
  assign rst      = clk.rst;

  CommitTrace_t mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [CYC_W-1:0] cyc_q;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;

  CommitTrace_t            cand  [TRACE_SLOTS];
  CommitTrace_t            dense [TRACE_SLOTS];
  logic [TRACE_SLOTS-1:0]  cand_valid;
  logic [SLOT_CNT_W-1:0]   n_cand;
  logic [SLOT_CNT_W-1:0]   n_push;
  logic [SLOT_CNT_W-1:0]   n_drop;
  logic [LW-1:0]           free_slots;
  logic                    pop;
  logic [16:0]             drop_sum;

  // Build the four candidates in slot order A-reg, A-hilo, B-reg, B-hilo.
  always_comb begin
    cand[0] = '{kind: TRACE_REG,  waddr: reg_wr1.waddr, wdata: {32'b0, reg_wr1.wdata}, cycle: 32'(cyc_q)};
    cand[1] = '{kind: TRACE_HILO, waddr: '0,            wdata: hilo_wr1.wdata,          cycle: 32'(cyc_q)};
    cand[2] = '{kind: TRACE_REG,  waddr: reg_wr2.waddr, wdata: {32'b0, reg_wr2.wdata}, cycle: 32'(cyc_q)};
    cand[3] = '{kind: TRACE_HILO, waddr: '0,            wdata: hilo_wr2.wdata,          cycle: 32'(cyc_q)};
    // Writes to $0 are architecturally invisible, so they never become records.
    cand_valid[0] = capture_en & reg_wr1.we & (reg_wr1.waddr != '0);
    cand_valid[1] = capture_en & hilo_wr1.we;
    cand_valid[2] = capture_en & reg_wr2.we & (reg_wr2.waddr != '0);
    cand_valid[3] = capture_en & hilo_wr2.we;
  end

  commit_trace_pack u_pack (
    .cand  (cand),
    .valid (cand_valid),
    .dense (dense),
    .count (n_cand)
  );

  // Space comes from the registered level only; a same-cycle pop does not help.
  always_comb begin
    free_slots = LW'(DEPTH) - level_q;
    if (LW'(n_cand) > free_slots) n_push = free_slots[SLOT_CNT_W-1:0];
    else                          n_push = n_cand;
    n_drop   = n_cand - n_push;
    pop      = (level_q != '0) && trace_ready;
    drop_sum = {1'b0, drop_cnt_q} + 17'(n_drop);
  end

  // Pointers, occupancy, cycle stamp and sticky drop accounting.
  always_ff @(posedge clk_base) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cyc_q   <= cyc_q + CYC_W'(1);
      wr_ptr  <= wr_ptr + PW'(n_push);
      rd_ptr  <= rd_ptr + PW'(pop);
      level_q <= level_q + LW'(n_push) - LW'(pop);
      if (n_drop != '0) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  // Record storage: the compacted candidates fill consecutive slots from wr_ptr.
  always_ff @(posedge clk_base) begin
    for (int i = 0; i < TRACE_SLOTS; i++) begin
      if (!rst && (SLOT_CNT_W'(i) < n_push)) mem[wr_ptr + PW'(i)] <= dense[i];
    end
  end

  assign trace_valid = (level_q != '0);
  assign trace       = mem[rd_ptr];
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
